// File: rtl/ble_packet_sequencer.sv
// BLE packet sequencer: walks header then payload bits, issues DMA word requests and TX/RX done IRQs.
// Optional BLE_SEQ_TIMEOUT_EN adds an idle-strobe watchdog that aborts the packet and sets err_o.
module ble_packet_sequencer #(
  parameter int CW     = 16,
  parameter int WORD_W = 32,
  parameter int TO_CYC = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          mode_i,
  input  logic          dma_mode_i,
  input  logic          tx_irq_en_i,
  input  logic          rx_irq_en_i,
  input  logic          tx_irq_clear_i,
  input  logic          rx_irq_clear_i,
  input  logic [CW-1:0] header_size_i,
  input  logic [CW-1:0] payload_size_i,
  input  logic          bit_strobe_i,
  output logic          dp_en_o,
  output logic          dp_mode_o,
  output logic          dp_phase_o,
  output logic [CW-1:0] bit_cnt_o,
  output logic          dma_req_o,
  output logic          busy_o,
  output logic          tx_irq_o,
  output logic          rx_irq_o,
  output logic          chain_clr_tx_irq_o,
  output logic          chain_clr_rx_irq_o,
  output logic          err_o
);

  localparam int WW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          en_q;
  logic          mode_q, mode_d, dma_q, dma_d;
  logic [CW-1:0] hdr_q, hdr_d, pay_q, pay_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          dma_req_q, dma_req_d;
  logic          tx_pend_q, tx_pend_d, rx_pend_q, rx_pend_d;
  logic          tx_irq_q, rx_irq_q, clr_tx_q, clr_rx_q;
  logic          start, active, timeout;
  logic          hdr_last, pay_last, word_end, tx_set, rx_set;

  // Start only on a fresh rising edge so a level held high after DONE cannot re-launch.
  assign start    = enable_i && !en_q && (state_q == S_IDLE);
  assign active   = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
  assign hdr_last = (bit_cnt_q == hdr_q - CW'(1));
  assign pay_last = (bit_cnt_q == pay_q - CW'(1));
  assign word_end = (wcnt_q == WW'(WORD_W - 1));
  assign tx_set   = (state_q == S_DONE) && !mode_q;
  assign rx_set   = (state_q == S_DONE) && mode_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dma_d     = dma_q;
    hdr_d     = hdr_q;
    pay_d     = pay_q;
    bit_cnt_d = bit_cnt_q;
    wcnt_d    = wcnt_q;
    dma_req_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode_i;
          dma_d     = dma_mode_i;
          hdr_d     = header_size_i;
          pay_d     = payload_size_i;
          bit_cnt_d = '0;
          wcnt_d    = '0;
          if (header_size_i != '0)       state_d = S_HEADER;
          else if (payload_size_i != '0) state_d = S_PAYLOAD;
          else                           state_d = S_DONE;
        end
      end
      S_HEADER: begin
        if (!enable_i) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else if (bit_strobe_i) begin
          if (hdr_last) begin
            bit_cnt_d = '0;
            if (pay_q != '0) state_d = S_PAYLOAD;
            else             state_d = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      S_PAYLOAD: begin
        if (!enable_i) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else if (bit_strobe_i) begin
          wcnt_d    = word_end ? '0 : wcnt_q + WW'(1);
          // A partial trailing word still needs one fetch.
          dma_req_d = dma_q && (word_end || pay_last);
          if (pay_last) begin
            bit_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end
  end

  // Setting a pending flag outranks a clear arriving in the same cycle.
  assign tx_pend_d = tx_set || (tx_pend_q && !tx_irq_clear_i);
  assign rx_pend_d = rx_set || (rx_pend_q && !rx_irq_clear_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      dma_q     <= 1'b0;
      hdr_q     <= '0;
      pay_q     <= '0;
      bit_cnt_q <= '0;
      wcnt_q    <= '0;
      dma_req_q <= 1'b0;
      tx_pend_q <= 1'b0;
      rx_pend_q <= 1'b0;
      tx_irq_q  <= 1'b0;
      rx_irq_q  <= 1'b0;
      clr_tx_q  <= 1'b0;
      clr_rx_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= enable_i;
      mode_q    <= mode_d;
      dma_q     <= dma_d;
      hdr_q     <= hdr_d;
      pay_q     <= pay_d;
      bit_cnt_q <= bit_cnt_d;
      wcnt_q    <= wcnt_d;
      dma_req_q <= dma_req_d;
      tx_pend_q <= tx_pend_d;
      rx_pend_q <= rx_pend_d;
      tx_irq_q  <= tx_pend_d && tx_irq_en_i;
      rx_irq_q  <= rx_pend_d && rx_irq_en_i;
      clr_tx_q  <= tx_irq_clear_i && !tx_set;
      clr_rx_q  <= rx_irq_clear_i && !rx_set;
    end
  end

`ifdef BLE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  assign timeout = active && !bit_strobe_i && (wd_q == TW'(TO_CYC - 1));

  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if (active && !bit_strobe_i && !timeout) wd_d = wd_q + TW'(1);
    if (start)   err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign dp_en_o            = active;
  assign dp_mode_o          = mode_q;
  assign dp_phase_o         = (state_q == S_PAYLOAD);
  assign bit_cnt_o          = bit_cnt_q;
  assign dma_req_o          = dma_req_q;
  assign busy_o             = (state_q != S_IDLE);
  assign tx_irq_o           = tx_irq_q;
  assign rx_irq_o           = rx_irq_q;
  assign chain_clr_tx_irq_o = clr_tx_q;
  assign chain_clr_rx_irq_o = clr_rx_q;

endmodule

// File: tb/tb_ble_packet_sequencer.sv
// Randomised scoreboard bench for ble_packet_sequencer: a packet-level model predicts event cycles.
module tb_ble_packet_sequencer;
  localparam int CW = 16, WORD_W = 32;
  localparam int K_DMA = 0, K_PH = 1, K_TXR = 2, K_TXF = 3, K_RXR = 4, K_RXF = 5, K_CT = 6, K_CR = 7;
  localparam int NK = 8;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          enable_i = 0, mode_i = 0, dma_mode_i = 0, tx_irq_en_i = 0, rx_irq_en_i = 0;
  logic          tx_irq_clear_i = 0, rx_irq_clear_i = 0, bit_strobe_i = 0;
  logic [CW-1:0] header_size_i = '0, payload_size_i = '0;
  logic          dp_en_o, dp_mode_o, dp_phase_o, dma_req_o, busy_o, tx_irq_o, rx_irq_o;
  logic          chain_clr_tx_irq_o, chain_clr_rx_irq_o, err_o;
  logic [CW-1:0] bit_cnt_o;

  int    compared = 0, mismatched = 0, cyc = 0;
  int    exp_q[NK][$];
  bit    mon_on = 0;
  logic  prev_ph = 0, prev_tx = 0, prev_rx = 0;
  string kname[NK] = '{"dma_req", "phase_rise", "tx_irq_rise", "tx_irq_fall",
                       "rx_irq_rise", "rx_irq_fall", "chain_tx", "chain_rx"};

  ble_packet_sequencer #(.CW(CW), .WORD_W(WORD_W), .TO_CYC(1024)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .mode_i(mode_i),
    .dma_mode_i(dma_mode_i), .tx_irq_en_i(tx_irq_en_i), .rx_irq_en_i(rx_irq_en_i),
    .tx_irq_clear_i(tx_irq_clear_i), .rx_irq_clear_i(rx_irq_clear_i),
    .header_size_i(header_size_i), .payload_size_i(payload_size_i),
    .bit_strobe_i(bit_strobe_i), .dp_en_o(dp_en_o), .dp_mode_o(dp_mode_o),
    .dp_phase_o(dp_phase_o), .bit_cnt_o(bit_cnt_o), .dma_req_o(dma_req_o),
    .busy_o(busy_o), .tx_irq_o(tx_irq_o), .rx_irq_o(rx_irq_o),
    .chain_clr_tx_irq_o(chain_clr_tx_irq_o), .chain_clr_rx_irq_o(chain_clr_rx_irq_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic ev(input int k);
    if (exp_q[k].size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected %s: got event at cycle %0d, expected none", kname[k], cyc);
    end else begin
      chk({kname[k], " cycle"}, cyc, exp_q[k].pop_front());
    end
  endtask

  // Monitor: every observed output event is matched against the model's predicted cycle.
  always @(negedge clk_i) begin
    if (mon_on) begin
      if (dma_req_o)                 ev(K_DMA);
      if (dp_phase_o && !prev_ph)    ev(K_PH);
      if (tx_irq_o && !prev_tx)      ev(K_TXR);
      if (!tx_irq_o && prev_tx)      ev(K_TXF);
      if (rx_irq_o && !prev_rx)      ev(K_RXR);
      if (!rx_irq_o && prev_rx)      ev(K_RXF);
      if (chain_clr_tx_irq_o)        ev(K_CT);
      if (chain_clr_rx_irq_o)        ev(K_CR);
    end
    prev_ph <= dp_phase_o;
    prev_tx <= tx_irq_o;
    prev_rx <= rx_irq_o;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_clr(input bit md, input bit v);
    if (md) rx_irq_clear_i = v;
    else    tx_irq_clear_i = v;
  endtask

  // One packet: predict events from the bit-count rules, then drive it.
  task automatic run_pkt(input int hdr, input int pay, input bit md, input bit dma,
                         input bit irq_en, input int dens, input int abort_off,
                         input bit coin_clr, input bit late_mask, input bit do_clr);
    bit pat[1024];
    int s, t, st, cnt, pcnt, done_t;
    bit aborted;
    for (int i = 0; i < 1024; i++) pat[i] = ($urandom_range(99) < dens);
    step();
    s = cyc;
    enable_i = 1; header_size_i = CW'(hdr); payload_size_i = CW'(pay);
    mode_i = md; dma_mode_i = dma; bit_strobe_i = 0;
    tx_irq_en_i = md ? 1'($urandom_range(1)) : irq_en;
    rx_irq_en_i = md ? irq_en : 1'($urandom_range(1));
    st = (hdr != 0) ? 1 : (pay != 0) ? 2 : 3;  // 1 header, 2 payload, 3 done
    if (st == 2) exp_q[K_PH].push_back(s + 1);
    cnt = 0; pcnt = 0; aborted = 0; done_t = -1; t = s + 1;
    while (done_t < 0 && !aborted && t < s + 1000) begin
      if (st == 3) done_t = t;
      else if (abort_off >= 0 && t == s + 1 + abort_off) aborted = 1;
      else begin
        if (pat[t-s-1]) begin
          if (st == 1) begin
            cnt++;
            if (cnt == hdr) begin
              st = (pay != 0) ? 2 : 3;
              if (pay != 0) exp_q[K_PH].push_back(t + 1);
            end
          end else begin
            pcnt++;
            if (dma && ((pcnt % WORD_W) == 0 || pcnt == pay)) exp_q[K_DMA].push_back(t + 1);
            if (pcnt == pay) st = 3;
          end
        end
        t++;
      end
    end
    if (done_t < 0 && !aborted) begin
      $display("FAIL model_bound: packet did not finish within 1000 cycles, expected completion");
      $fatal(1, "model bound exceeded");
    end
    if (done_t >= 0 && irq_en) exp_q[md ? K_RXR : K_TXR].push_back(done_t + 1);
    for (int u = s + 1; u <= t; u++) begin
      step();
      if (u == s + 1) begin
        chk("start_bit_cnt", int'(bit_cnt_o), 0);
        chk("start_dp_en", int'(dp_en_o), (hdr != 0 || pay != 0) ? 1 : 0);
        chk("start_busy", int'(busy_o), 1);
        chk("start_dp_mode", int'(dp_mode_o), int'(md));
      end
      bit_strobe_i   = pat[u-s-1];
      header_size_i  = CW'($urandom);
      payload_size_i = CW'($urandom);
      mode_i         = 1'($urandom_range(1));
      dma_mode_i     = 1'($urandom_range(1));
      if (aborted && u == t) enable_i = 0;
      if (!aborted && u == t && coin_clr) set_clr(md, 1);
    end
    step();
    bit_strobe_i = 0;
    set_clr(md, 0);
    if (aborted) begin
      chk("abort_dp_en", int'(dp_en_o), 0);
      chk("abort_bit_cnt", int'(bit_cnt_o), 0);
      chk("abort_busy", int'(busy_o), 0);
    end else begin
      chk("done_idle_busy", int'(busy_o), 0);
      step();
      chk("no_restart_busy", int'(busy_o), 0);
      enable_i = 0;
      if (!irq_en && late_mask) begin
        step();
        if (md) rx_irq_en_i = 1; else tx_irq_en_i = 1;
        exp_q[md ? K_RXR : K_TXR].push_back(cyc + 1);
      end
    end
    if (do_clr || !aborted) begin
      step();
      set_clr(md, 1);
      if (!aborted && (irq_en || late_mask)) exp_q[md ? K_RXF : K_TXF].push_back(cyc + 1);
      exp_q[md ? K_CR : K_CT].push_back(cyc + 1);
      step();
      set_clr(md, 0);
    end
    step();
  endtask

  initial begin
    int hdr, pay;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_dp_en", int'(dp_en_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_bit_cnt", int'(bit_cnt_o), 0);
    chk("reset_dp_phase", int'(dp_phase_o), 0);
    chk("reset_dma_req", int'(dma_req_o), 0);
    chk("reset_irqs", int'({tx_irq_o, rx_irq_o}), 0);
    chk("reset_chain", int'({chain_clr_tx_irq_o, chain_clr_rx_irq_o}), 0);
    chk("reset_err", int'(err_o), 0);
    rst_ni = 1;
    mon_on = 1;
    step();
    run_pkt(16, 64, 0, 1, 1, 100, -1, 0, 0, 1);  // TX, two full words
    run_pkt(0, 40, 1, 1, 1, 100, -1, 0, 0, 1);   // RX, no header, partial last word
    run_pkt(0, 0, 0, 0, 1, 100, -1, 0, 0, 1);    // empty packet
    run_pkt(20, 30, 0, 1, 1, 100, 5, 0, 0, 0);   // abort at header bit 5
    run_pkt(8, 16, 0, 0, 1, 100, -1, 0, 0, 1);   // restart from bit 0
    run_pkt(4, 32, 0, 1, 1, 100, -1, 1, 0, 1);   // clear coincident with DONE
    run_pkt(4, 8, 1, 0, 0, 100, -1, 0, 1, 1);    // masked pending, unmasked later
    run_pkt(3, 5, 1, 0, 1, 100, 2, 0, 0, 1);     // clear with nothing pending
    for (int n = 0; n < 40; n++) begin
      hdr = $urandom_range(0, 40);
      pay = $urandom_range(0, 100);
      run_pkt(hdr, pay, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              $urandom_range(50, 100),
              ($urandom_range(3) == 0) ? int'($urandom_range(0, hdr + pay + 20)) : -1,
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    repeat (4) step();
    for (int k = 0; k < NK; k++) chk({"leftover ", kname[k]}, exp_q[k].size(), 0);
    chk("err_default", int'(err_o), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
